// File: rtl/gpu_pkg.sv
// Shared GPU front-end types: shape/segment encodings, opcode field layout
// and the segment-order helpers used by the sequencer and the splitter.
package gpu_pkg;

    localparam int OPDATA_W = 74;
    localparam int COLOR_W  = 16;
    localparam int LOC_W    = 19;

    localparam int FILL_BIT  = 0;
    localparam int LOC3_LSB  = 1;
    localparam int LOC2_LSB  = 20;
    localparam int LOC1_LSB  = 39;
    localparam int COLOR_LSB = 58;

    typedef enum logic [1:0] {
        SHAPE_LINE     = 2'd0,
        SHAPE_TRIANGLE = 2'd1,
        SHAPE_CIRCLE   = 2'd2,
        SHAPE_RSVD     = 2'd3
    } shape_t;

    typedef enum logic [3:0] {
        SEL_L1   = 4'd0,
        SEL_TRI1 = 4'd1,
        SEL_TRI2 = 4'd2,
        SEL_TRI3 = 4'd3,
        SEL_CIR1 = 4'd4
    } sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Only the first two triangle edges have a successor; everything else ends the shape.
    function automatic logic is_last_seg(input sel_t sel);
        case (sel)
            SEL_TRI1, SEL_TRI2: return 1'b0;
            default:            return 1'b1;
        endcase
    endfunction

    function automatic sel_t next_seg(input sel_t sel);
        case (sel)
            SEL_TRI1: return SEL_TRI2;
            SEL_TRI2: return SEL_TRI3;
            default:  return sel;
        endcase
    endfunction

endpackage

// File: rtl/shape_sequencer_flex_counter.sv
// Saturating up-counter with synchronous clear; the flag marks that the
// count currently equals rollover_val.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] count_r;
    logic [NUM_CNT_BITS-1:0] count_next_s;
    logic                    flag_r;

    // Next count: clear dominates, then hold at the limit instead of wrapping.
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = '0;
        end else if (count_enable && (count_r != rollover_val)) begin
            count_next_s = count_r + ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and flag registers; the flag tracks the value being loaded.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_r <= '0;
            flag_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            flag_r  <= (count_next_s == rollover_val);
        end
    end

    assign rollover_flag = flag_r;

endmodule

// File: rtl/shape_sequencer.sv
// Control stage of the opcode splitter: latches one draw opcode and steps
// output_sel through its segments, handshaking each with the raster engine.
module shape_sequencer
    import gpu_pkg::*;
#(
    parameter int                   TIMEOUT_W = 20,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'hFFFFF
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                op_valid,
    input  logic [1:0]          op_shape,
    input  logic [OPDATA_W-1:0] op_data,
    output logic                op_ready,
    output logic [OPDATA_W-1:0] opdata,
    output logic [3:0]          output_sel,
    output logic                draw_start,
    output logic                draw_circle,
    input  logic                draw_done,
    output logic                busy,
    output logic                shape_done,
    output logic                err_shape,
    output logic                err_timeout
);

    localparam logic [TIMEOUT_W-1:0] WD_ONE   = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WD_LIMIT = TIMEOUT - WD_ONE;
    localparam logic                 WD_ON    = (TIMEOUT != '0);

    seq_state_t          state_r, next_state_s;
    sel_t                sel_r, sel_next_s;
    logic [OPDATA_W-1:0] opdata_r, opdata_next_s;
    logic                draw_start_r, draw_start_next_s;
    logic                shape_done_r, shape_done_next_s;
    logic                err_shape_r, err_shape_next_s;
    logic                err_timeout_r, err_timeout_next_s;
    logic                wd_flag_s;
    logic                timeout_hit_s;
    shape_t              shape_s;

    assign shape_s = shape_t'(op_shape);

    flex_counter #(
        .NUM_CNT_BITS (TIMEOUT_W)
    ) u_watchdog (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state_r == ST_ISSUE),
        .count_enable  (state_r == ST_WAIT),
        .rollover_val  (WD_LIMIT),
        .rollover_flag (wd_flag_s)
    );

    // A finishing segment always beats an expiring watchdog in the same cycle.
    assign timeout_hit_s = WD_ON && wd_flag_s && (state_r == ST_WAIT) && !draw_done;

    // Registered state, segment select, latched opcode and pulse outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r       <= ST_IDLE;
            sel_r         <= SEL_L1;
            opdata_r      <= '0;
            draw_start_r  <= 1'b0;
            shape_done_r  <= 1'b0;
            err_shape_r   <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            sel_r         <= sel_next_s;
            opdata_r      <= opdata_next_s;
            draw_start_r  <= draw_start_next_s;
            shape_done_r  <= shape_done_next_s;
            err_shape_r   <= err_shape_next_s;
            err_timeout_r <= err_timeout_next_s;
        end
    end

    // Next-state, segment-select and opcode-latch decision.
    always_comb begin
        next_state_s  = state_r;
        sel_next_s    = sel_r;
        opdata_next_s = opdata_r;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    case (shape_s)
                        SHAPE_LINE: begin
                            opdata_next_s = op_data;
                            sel_next_s    = SEL_L1;
                            next_state_s  = ST_ISSUE;
                        end
                        SHAPE_TRIANGLE: begin
                            opdata_next_s = op_data;
                            sel_next_s    = SEL_TRI1;
                            next_state_s  = ST_ISSUE;
                        end
                        SHAPE_CIRCLE: begin
                            opdata_next_s = op_data;
                            sel_next_s    = SEL_CIR1;
                            next_state_s  = ST_ISSUE;
                        end
                        default: begin
                            next_state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (draw_done) begin
                    if (is_last_seg(sel_r)) begin
                        next_state_s = ST_DONE;
                    end else begin
                        sel_next_s   = next_seg(sel_r);
                        next_state_s = ST_ISSUE;
                    end
                end else if (timeout_hit_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Pulse outputs are computed one cycle early so they line up with the state they mark.
    always_comb begin
        draw_start_next_s  = (next_state_s == ST_ISSUE);
        shape_done_next_s  = (next_state_s == ST_DONE);
        err_shape_next_s   = (state_r == ST_IDLE) && op_valid && (shape_s == SHAPE_RSVD);
        err_timeout_next_s = timeout_hit_s;
    end

    assign op_ready    = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign draw_circle = (sel_r == SEL_CIR1);
    assign output_sel  = sel_r;
    assign opdata      = opdata_r;
    assign draw_start  = draw_start_r;
    assign shape_done  = shape_done_r;
    assign err_shape   = err_shape_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_shape_sequencer.sv
// Directed bench for shape_sequencer: a cycle table for the basic handshake
// plus hand-written multi-cycle sequences (triangle, watchdog, reset, spacing).
module tb_shape_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        op_valid;
    logic [1:0]  op_shape;
    logic [73:0] op_data;
    logic        op_ready;
    logic [73:0] opdata;
    logic [3:0]  output_sel;
    logic        draw_start;
    logic        draw_circle;
    logic        draw_done;
    logic        busy;
    logic        shape_done;
    logic        err_shape;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shape_sequencer #(
        .TIMEOUT_W (20),
        .TIMEOUT   (20'd16)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .op_valid    (op_valid),
        .op_shape    (op_shape),
        .op_data     (op_data),
        .op_ready    (op_ready),
        .opdata      (opdata),
        .output_sel  (output_sel),
        .draw_start  (draw_start),
        .draw_circle (draw_circle),
        .draw_done   (draw_done),
        .busy        (busy),
        .shape_done  (shape_done),
        .err_shape   (err_shape),
        .err_timeout (err_timeout)
    );

    // flags = {op_ready, busy, draw_start, shape_done, err_shape, err_timeout, draw_circle}
    typedef struct {
        logic        rn;
        logic        v;
        logic [1:0]  sh;
        logic [73:0] d;
        logic        dn;
        logic [6:0]  ef;
        logic [3:0]  es;
        logic [73:0] eo;
    } vec_t;

    vec_t vt[0:15];
    int   nv = 0;

    localparam logic [73:0] D_LINE = 74'h1F800_0000_1234_5678;
    localparam logic [73:0] D_A    = 74'h0A5A5_1111_2222_3333;
    localparam logic [73:0] D_B    = 74'h2AAAA_BBBB_CCCC_DDDD;
    localparam logic [73:0] D_C    = 74'h301234567_89AB_CDEF_0;
    localparam logic [73:0] D_T    = 74'h0F0F0_F0F0_F0F0_F0F0;

    // Run-time observations filled by run_shape.
    int         n_starts, n_sdone, n_tout, since, sd_since, to_since, rdy_bad;
    logic [3:0] sel_log [0:3];
    logic       start_circ;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic rn, input logic v, input logic [1:0] sh, input logic [73:0] d,
                           input logic dn, input logic [6:0] ef, input logic [3:0] es, input logic [73:0] eo);
        vt[nv] = '{rn: rn, v: v, sh: sh, d: d, dn: dn, ef: ef, es: es, eo: eo};
        nv++;
    endtask

    function automatic logic [6:0] flags();
        return {op_ready, busy, draw_start, shape_done, err_shape, err_timeout, draw_circle};
    endfunction

    // Issue one opcode, answer each segment 'delay' cycles after its start (-1 = never).
    task automatic run_shape(input logic [1:0] sh, input logic [73:0] d, input int delay, input int budget);
        n_starts = 0; n_sdone = 0; n_tout = 0; since = 0;
        sd_since = -1; to_since = -1; rdy_bad = 0; start_circ = 1'b0;
        for (int i = 0; i < 4; i++) sel_log[i] = 4'hF;
        op_valid = 1'b1; op_shape = sh; op_data = d; draw_done = 1'b0;
        tick();
        op_valid = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (draw_start) begin
                if (n_starts < 4) sel_log[n_starts] = output_sel;
                start_circ = draw_circle;
                n_starts++;
                since = 0;
            end else begin
                since++;
            end
            if (err_timeout) begin
                n_tout++;
                to_since = since;
            end
            if (n_sdone == 0 && n_tout == 0 && op_ready) rdy_bad++;
            if (shape_done) begin
                n_sdone++;
                sd_since = since;
            end
            draw_done = (delay >= 0 && n_starts > 0 && since == delay) ? 1'b1 : 1'b0;
            tick();
        end
        draw_done = 1'b0;
    endtask

    initial begin
        int acc[$];
        int found;

        n_rst = 1'b0; op_valid = 1'b0; op_shape = 2'd0; op_data = '0; draw_done = 1'b0;

        add_vec(1'b0, 1'b0, 2'd0, D_A,  1'b0, 7'b1000000, 4'd0, 74'd0); // reset
        add_vec(1'b1, 1'b1, 2'd0, D_A,  1'b0, 7'b0110000, 4'd0, D_A);   // line accepted
        add_vec(1'b1, 1'b0, 2'd0, D_B,  1'b0, 7'b0100000, 4'd0, D_A);   // WAIT
        add_vec(1'b1, 1'b0, 2'd0, D_B,  1'b1, 7'b0101000, 4'd0, D_A);   // done -> DONE
        add_vec(1'b1, 1'b0, 2'd0, D_B,  1'b0, 7'b1000000, 4'd0, D_A);   // IDLE
        add_vec(1'b1, 1'b1, 2'd3, D_B,  1'b0, 7'b1000100, 4'd0, D_A);   // reserved shape
        add_vec(1'b1, 1'b0, 2'd3, D_B,  1'b0, 7'b1000000, 4'd0, D_A);
        add_vec(1'b1, 1'b1, 2'd2, D_C,  1'b0, 7'b0110001, 4'd4, D_C);   // circle accepted
        add_vec(1'b1, 1'b0, 2'd2, D_B,  1'b1, 7'b0100001, 4'd4, D_C);   // done in ISSUE ignored
        add_vec(1'b1, 1'b0, 2'd2, D_B,  1'b0, 7'b0100001, 4'd4, D_C);
        add_vec(1'b1, 1'b0, 2'd2, D_B,  1'b1, 7'b0101001, 4'd4, D_C);   // DONE
        add_vec(1'b1, 1'b0, 2'd2, D_B,  1'b0, 7'b1000001, 4'd4, D_C);
        add_vec(1'b1, 1'b0, 2'd2, D_B,  1'b1, 7'b1000001, 4'd4, D_C);   // done in IDLE ignored

        for (int i = 0; i < nv; i++) begin
            n_rst = vt[i].rn; op_valid = vt[i].v; op_shape = vt[i].sh;
            op_data = vt[i].d; draw_done = vt[i].dn;
            tick();
            chk($sformatf("vec%0d_flags_sel", i), {flags(), output_sel}, {vt[i].ef, vt[i].es});
            chk($sformatf("vec%0d_opdata", i), opdata, vt[i].eo);
        end
        op_valid = 1'b0; draw_done = 1'b0;
        tick();

        run_shape(2'd0, D_LINE, 5, 12);
        chk("line_starts", n_starts, 1);
        chk("line_sel", sel_log[0], 4'd0);
        chk("line_sdone", n_sdone, 1);
        chk("line_sdone_lat", sd_since, 6);
        chk("line_opdata", opdata, D_LINE);
        chk("line_no_timeout", n_tout, 0);

        run_shape(2'd1, D_T, 3, 20);
        chk("tri_starts", n_starts, 3);
        chk("tri_order", {sel_log[0], sel_log[1], sel_log[2]}, {4'd1, 4'd2, 4'd3});
        chk("tri_sdone", n_sdone, 1);
        chk("tri_ready_low", rdy_bad, 0);

        run_shape(2'd2, D_B, 2, 10);
        chk("cir_starts", n_starts, 1);
        chk("cir_sel", sel_log[0], 4'd4);
        chk("cir_draw_circle", start_circ, 1'b1);
        chk("cir_ready_low", rdy_bad, 0);
        chk("cir_sdone", n_sdone, 1);

        run_shape(2'd0, D_A, -1, 24);
        chk("wd_timeout", n_tout, 1);
        chk("wd_timeout_lat", to_since, 17);
        chk("wd_no_sdone", n_sdone, 0);
        chk("wd_idle", {op_ready, busy}, 2'b10);

        run_shape(2'd0, D_A, 16, 24);
        chk("wd_race_no_timeout", n_tout, 0);
        chk("wd_race_sdone", n_sdone, 1);
        chk("wd_race_lat", sd_since, 17);

        // Reset during the WAIT of the second triangle edge.
        op_valid = 1'b1; op_shape = 2'd1; op_data = D_T;
        tick();
        op_valid = 1'b0;
        found = 0; since = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (draw_start) since = 0; else since++;
            if (draw_start && output_sel == 4'd2) begin
                found = 1;
            end else begin
                draw_done = (since == 3) ? 1'b1 : 1'b0;
                tick();
            end
        end
        draw_done = 1'b0;
        chk("rst_reached_tri2", found, 1);
        tick();
        chk("rst_in_wait", {busy, output_sel}, {1'b1, 4'd2});
        n_rst = 1'b0;
        tick();
        chk("rst_state", {flags(), output_sel}, {7'b1000000, 4'd0});
        chk("rst_opdata", opdata, 74'd0);
        n_rst = 1'b1;
        tick();
        chk("rst_no_pulse", {flags(), output_sel}, {7'b1000000, 4'd0});

        // Back-to-back lines with done held high: accepts every 4 cycles.
        op_valid = 1'b1; op_shape = 2'd0; op_data = D_LINE; draw_done = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (op_ready) acc.push_back(c);
            tick();
        end
        op_valid = 1'b0; draw_done = 1'b0;
        chk("b2b_count", acc.size(), 4);
        if (acc.size() >= 3) begin
            chk("b2b_space0", acc[1] - acc[0], 4);
            chk("b2b_space1", acc[2] - acc[1], 4);
        end else begin
            errors++;
            $display("FAIL b2b_space actual=%0d accepts required=4", acc.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
